// File: rtl/alu_unit.sv
// 32-bit integer ALU with a single registered output stage.
// Result, valid strobe and zero flag appear one clock after an accepted input.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       ALU_Sel,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_SLT = 4'b1000
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result_d, result_q;
  logic             out_valid_d, out_valid_q;

  assign op = alu_op_e'(ALU_Sel);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = operand_0 + operand_1;
      OP_SUB: alu_res = operand_0 - operand_1;
      OP_AND: alu_res = operand_0 & operand_1;
      OP_OR:  alu_res = operand_0 | operand_1;
      OP_XOR: alu_res = operand_0 ^ operand_1;
      // Shifts are fixed at one bit; operand_1 never reaches them.
      OP_SLL: alu_res = {operand_0[WIDTH-2:0], 1'b0};
      OP_SRL: alu_res = {1'b0, operand_0[WIDTH-1:1]};
      OP_SRA: alu_res = {operand_0[WIDTH-1], operand_0[WIDTH-1:1]};
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_0) < $signed(operand_1))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    result_d    = in_valid ? alu_res : result_q;
    out_valid_d = in_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed table, reset corner cases,
// and randomized traffic against an arithmetic reference model.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  ALU_Sel;
  logic [31:0] operand_0;
  logic [31:0] operand_1;
  logic [31:0] result;
  logic        out_valid;
  logic        zero;

  int n_vec = 0;
  int n_err = 0;

  alu_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ALU_Sel   (ALU_Sel),
    .operand_0 (operand_0),
    .operand_1 (operand_1),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model written from the arithmetic definition of each opcode.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    int sa, sb;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0: return 32'((ua + ub) % 64'h1_0000_0000);
      4'd1: return 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return 32'((ua * 2) % 64'h1_0000_0000);
      4'd6: return 32'(ua / 2);
      4'd7: return 32'(ua / 2) + ((sa < 0) ? 32'h8000_0000 : 32'h0);
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of inputs at the falling edge and sample just after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r; in_valid = v; ALU_Sel = op; operand_0 = a; operand_1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] exp_res, input logic exp_v);
    check({name, ".result"}, result, exp_res);
    check({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_v});
    check({name, ".zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'd0)});
  endtask

  vec_t        tbl[17];
  logic [31:0] exp_result;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;
  logic        r_v;

  initial begin
    tbl[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[1]  = '{4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    tbl[2]  = '{4'b0001, 32'h00000005, 32'h00000003, 32'h00000002};
    tbl[3]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    tbl[4]  = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    tbl[5]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    tbl[6]  = '{4'b0101, 32'h80000001, 32'h0000001F, 32'h00000002};
    tbl[7]  = '{4'b0110, 32'h80000001, 32'h0000001F, 32'h40000000};
    tbl[8]  = '{4'b0111, 32'h80000001, 32'h0000001F, 32'hC0000000};
    tbl[9]  = '{4'b0111, 32'h7FFFFFFE, 32'h0000001F, 32'h3FFFFFFF};
    tbl[10] = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    tbl[11] = '{4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    tbl[12] = '{4'b1000, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
    tbl[13] = '{4'b1000, 32'h12345678, 32'h12345678, 32'h00000000};
    tbl[14] = '{4'b1010, 32'hDEADBEEF, 32'h12345678, 32'h00000000};
    tbl[15] = '{4'b0000, 32'h00000007, 32'h00000009, 32'h00000010};
    tbl[16] = '{4'b0101, 32'h40000000, 32'hFFFFFFFF, 32'h80000000};

    rst = 1'b1; in_valid = 1'b0; ALU_Sel = 4'b0; operand_0 = '0; operand_1 = '0;

    // Reset for two cycles, then idle.
    step(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
    expect_out("reset", 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
      expect_out($sformatf("idle%0d", i), 32'h0, 1'b0);
    end

    // Directed table, issued back-to-back every cycle.
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      expect_out($sformatf("tbl%0d", i), tbl[i].exp, 1'b1);
    end

    // Idle after an op: strobe drops, result holds.
    step(1'b0, 1'b0, 4'b0000, 32'h11111111, 32'h22222222);
    expect_out("hold0", tbl[16].exp, 1'b0);
    step(1'b0, 1'b0, 4'b0001, 32'h33333333, 32'h44444444);
    expect_out("hold1", tbl[16].exp, 1'b0);

    // Reset wins over a simultaneous accept, then the same op goes through.
    step(1'b1, 1'b1, 4'b0000, 32'h00000001, 32'h00000001);
    expect_out("rstprio", 32'h0, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 32'h00000001, 32'h00000001);
    expect_out("afterrst", 32'h00000002, 1'b1);

    // Mid-stream reset drops the pending output.
    step(1'b0, 1'b1, 4'b0011, 32'h0000F000, 32'h00000F00);
    expect_out("pre_mid", 32'h0000FF00, 1'b1);
    step(1'b1, 1'b1, 4'b0100, 32'hAAAAAAAA, 32'h55555555);
    expect_out("midrst", 32'h0, 1'b0);

    // Randomized traffic with random bubbles.
    exp_result = 32'h0;
    for (int i = 0; i < 300; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
      if ($urandom_range(0, 7) == 0) r_a = {r_a[31], 31'h0};
      r_v  = ($urandom_range(0, 3) != 0);
      step(1'b0, r_v, r_op, r_a, r_b);
      if (r_v) exp_result = model(r_op, r_a, r_b);
      expect_out($sformatf("rnd%0d_op%0d", i, r_op), exp_result, r_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
